// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared constants for the ALU command controller: frame opcodes, FSM states
// and the default result timeout.
package alu_cmd_ctrl_pkg;

    localparam logic [7:0] OP_AB_FRAME  = 8'hCC;
    localparam logic [7:0] OP_FUN_FRAME = 8'hDD;
    localparam int         DEFAULT_TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_RUN,
        WAIT_RES,
        SEND
    } state_t;

endpackage

// File: rtl/alu_cmd_ctrl_ser.sv
// Result serializer: captures the ALU result and streams it out LSB byte first
// over a valid/ready byte interface.
module alu_res_ser #(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [OUT_WIDTH-1:0] din,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 last_acc
);

    localparam int NBYTES = OUT_WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [NBYTES-1:0][7:0] res_q;
    logic [CW-1:0]          byte_cnt;
    logic                   acc;

    assign acc      = tx_valid & tx_ready;
    assign last_acc = acc & (byte_cnt == CW'(NBYTES - 1));
    assign tx_data  = res_q[byte_cnt];

    // byte_cnt only moves on an accepted byte, so tx_data stays put while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q    <= '0;
            byte_cnt <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            res_q    <= din;
            byte_cnt <= '0;
            tx_valid <= 1'b1;
        end else if (acc) begin
            if (last_acc) begin
                byte_cnt <= '0;
                tx_valid <= 1'b0;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-command front end for an ALU: parses CC/DD frames, runs the ALU once,
// waits (bounded) for its result and hands it to the serializer.
module alu_cmd_ctrl
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int OPER_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * OPER_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [OUT_WIDTH-1:0]  ALU_out,
    input  logic                  Out_valid,
    input  logic                  tx_ready,
    output logic [OPER_WIDTH-1:0] ALU_A,
    output logic [OPER_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic [TW-1:0] wait_cnt;
    logic          load_a, load_b, load_fun, res_load, last_acc;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_FUN  <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= (state == WAIT_RES) ? wait_cnt + 1'b1 : '0;
            if (load_a)   ALU_A   <= OPER_WIDTH'(rx_data);
            if (load_b)   ALU_B   <= OPER_WIDTH'(rx_data);
            if (load_fun) ALU_FUN <= rx_data[3:0];
        end
    end

    always_comb begin
        state_n  = state;
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_fun = 1'b0;
        res_load = 1'b0;
        ALU_EN   = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == OP_AB_FRAME)       state_n = GET_A;
                else if (rx_valid && rx_data == OP_FUN_FRAME) state_n = GET_FUN;
            end
            GET_A: if (rx_valid) begin
                load_a  = 1'b1;
                state_n = GET_B;
            end
            GET_B: if (rx_valid) begin
                load_b  = 1'b1;
                state_n = GET_FUN;
            end
            GET_FUN: if (rx_valid) begin
                load_fun = 1'b1;
                state_n  = ALU_RUN;
            end
            ALU_RUN: begin
                ALU_EN  = 1'b1;
                err     = rx_valid;
                state_n = WAIT_RES;
            end
            WAIT_RES: begin
                err = rx_valid;
                // a result arriving on the last allowed cycle still wins over the timeout
                if (Out_valid) begin
                    res_load = 1'b1;
                    state_n  = SEND;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end
            end
            SEND: begin
                err = rx_valid;
                if (last_acc) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    alu_res_ser #(.OUT_WIDTH(OUT_WIDTH)) u_ser (
        .clk      (CLK),
        .reset    (Reset),
        .load     (res_load),
        .din      (ALU_out),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .last_acc (last_acc)
    );

endmodule
